paula_audio_mixer: RTL and testbench
====================================

# paula_audio_mixer

Four-channel audio mixer feeding the hybrid PWM/sigma-delta DAC stage. Accepts four 8-bit signed channel samples with 7-bit volumes, one per Paula-style audio channel. On each sample strobe it snapshots all inputs and time-multiplexes a single 8x7 multiplier across the channels. It then emits 16-bit offset-binary left/right words suitable as the DAC `din`, with a one-cycle valid pulse.

## Interface
- `STEREO`, default 1: 1 = Amiga mapping (ch0+ch3 to left, ch1+ch2 to right); 0 = mono, all four channels summed onto both outputs.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `n_reset`  in  1  reset: one clock; reset is asynchronous and active-low.
- `sample_strobe`  in  1  request one mix; sampled on the rising edge.
- `ch0_sample`..`ch3_sample`  in  8 each  two's-complement channel samples.
- `ch0_vol`..`ch3_vol`  in  7 each  unsigned volume; 0..64 linear, values above 64 are treated as 64.
- `left_out`  out  16  left mix, offset binary (0x8000 = silence).
- `right_out`  out  16  right mix, offset binary.
- `out_valid`  out  1  one-cycle pulse when `left_out`/`right_out` update.
- `busy`  out  1  high while a mix is in progress.

## Operation
- States: IDLE, MAC0, MAC1, MAC2, MAC3, OUT.
- IDLE with `sample_strobe`=1:
  - latch all 8 sample/volume inputs into a snapshot; clamp volumes to 64.
  - clear both 17-bit signed accumulators; enter MAC0.
- MACn: product = sample_n (signed 8) x vol_n (unsigned 7, as signed 8).
  - Product range is -8192..+8128, 15-bit signed.
  - STEREO=1: ch0 and ch3 add to the left accumulator; ch1 and ch2 add to the right.
  - STEREO=0: every product adds to the left accumulator only.
  - MAC3 then enters OUT.
- OUT: form the signed 16-bit results.
  - STEREO=1: result = acc << 1. The range is -32768..+32512, so no overflow.
  - STEREO=0: result = acc. The range is the same; both outputs take the left result.
  - Offset binary: out = result XOR 0x8000.
  - Register `left_out`/`right_out`; pulse `out_valid`; return to IDLE.
- Only one multiplier is instantiated, shared across MAC0..MAC3.
- Input changes after the strobe edge have no effect on the current mix, because the snapshot is used throughout.
- `sample_strobe` while `busy`=1 (any state other than IDLE) is ignored, not queued.
- Outputs hold their last values between mixes.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE; `busy`=0; `out_valid`=0.
  - `left_out`=`right_out`=0x8000 (mid-scale, so the DAC idles at 50%).
  - Accumulators and snapshot are cleared.
  - A mix in progress is abandoned and no `out_valid` is produced.
- Strobe accepted at edge T (state was IDLE before T): `busy`=1 after T.
- Edges T+1..T+4 perform MAC0..MAC3.
- Edge T+5 updates the outputs:
  - `out_valid`=1 for the cycle following T+5.
  - `busy`=0 after T+5.
- Latency from strobe edge to updated outputs is 5 clocks.
- A strobe held high at edge T+5 is ignored, because the state is still OUT before that edge.
- The earliest next accepted strobe is edge T+6, giving a maximum throughput of one mix per 6 clocks.
- A strobe held continuously high produces a mix every 6 clocks.
- Outputs are glitch-free: `left_out`/`right_out` change only at the OUT edge.

## Test plan
- Reset check:
  - assert `n_reset`=0 mid-mix (at T+2), then release.
  - Expect `left_out`=`right_out`=0x8000, `busy`=0, no `out_valid` pulse; the next strobe produces a normal result.
- STEREO=1 full scale positive:
  - all samples 127, all vols 64.
  - Expect `out_valid` 5 clocks after the strobe edge; `left_out`=`right_out`=0xFF00.
- STEREO=1 full scale negative and separation:
  - ch0=ch3=-128 with vol 64; ch1=ch2=0.
  - Expect `left_out`=0x0000, `right_out`=0x8000.
- Volume clamp and snapshot:
  - ch1=64 with vol 100; change ch1 to -64 at T+1.
  - Expect `right_out`=0x8000+(4096<<1)=0xA000; `left_out`=0x8000.
- STEREO=0 mono:
  - all samples 127, vols 64.
  - Expect both outputs 0xFF00.
  - Then ch2=-1 with vol 1, others vol 0: expect both outputs 0x7FFF.
- Strobe during busy:
  - hold `sample_strobe` high continuously.
  - Expect `out_valid` pulses exactly 6 clocks apart and no strobes accepted while `busy`=1.

Source files
------------

// File: rtl/paula_audio_mixer_if.sv
// Channel inputs and mixed outputs between a sample source and the audio mixer.
// The master drives the strobe, samples and volumes; the slave returns the mixed words.
interface paula_audio_mixer_if;
  logic       sample_strobe;
  logic [7:0] ch0_sample;
  logic [7:0] ch1_sample;
  logic [7:0] ch2_sample;
  logic [7:0] ch3_sample;
  logic [6:0] ch0_vol;
  logic [6:0] ch1_vol;
  logic [6:0] ch2_vol;
  logic [6:0] ch3_vol;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic        out_valid;
  logic        busy;

  modport master (
    output sample_strobe, ch0_sample, ch1_sample, ch2_sample, ch3_sample,
           ch0_vol, ch1_vol, ch2_vol, ch3_vol,
    input  left_out, right_out, out_valid, busy
  );

  modport slave (
    input  sample_strobe, ch0_sample, ch1_sample, ch2_sample, ch3_sample,
           ch0_vol, ch1_vol, ch2_vol, ch3_vol,
    output left_out, right_out, out_valid, busy
  );
endinterface

// File: rtl/paula_audio_mixer.sv
// Four-channel Paula-style mixer: one shared 8x7 multiplier walks the channels,
// then emits offset-binary left/right words for the DAC with a one-cycle valid.
module paula_audio_mixer #(
  parameter bit STEREO = 1'b1
) (
  input  logic clk,
  input  logic n_reset,
  paula_audio_mixer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, OUT} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]         w_in_smp   [4];
  logic [6:0]         w_in_vol   [4];
  logic [6:0]         w_vol_clamp[4];
  logic [7:0]         r_smp      [4];
  logic [6:0]         r_vol      [4];
  logic signed [16:0] r_acc_l;
  logic signed [16:0] r_acc_r;
  logic [15:0]        r_left_out;
  logic [15:0]        r_right_out;
  logic               r_out_valid;

  logic [1:0]         w_ch;
  logic [7:0]         w_mul_s;
  logic [6:0]         w_mul_v;
  logic signed [15:0] w_mul_a;
  logic signed [15:0] w_mul_b;
  logic signed [15:0] w_prod16;
  logic signed [16:0] w_prod;
  logic               w_to_left;
  logic [15:0]        w_res_l;
  logic [15:0]        w_res_r;

  assign w_in_smp[0] = bus.ch0_sample;
  assign w_in_smp[1] = bus.ch1_sample;
  assign w_in_smp[2] = bus.ch2_sample;
  assign w_in_smp[3] = bus.ch3_sample;
  assign w_in_vol[0] = bus.ch0_vol;
  assign w_in_vol[1] = bus.ch1_vol;
  assign w_in_vol[2] = bus.ch2_vol;
  assign w_in_vol[3] = bus.ch3_vol;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_clamp
      assign w_vol_clamp[gi] = (w_in_vol[gi] > 7'd64) ? 7'd64 : w_in_vol[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.sample_strobe) w_state_next = MAC0;
      MAC0:    w_state_next = MAC1;
      MAC1:    w_state_next = MAC2;
      MAC2:    w_state_next = MAC3;
      MAC3:    w_state_next = OUT;
      OUT:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Channel selected for the shared multiplier in each MAC state.
  always_comb begin
    w_ch = 2'd0;
    case (r_state)
      MAC1:    w_ch = 2'd1;
      MAC2:    w_ch = 2'd2;
      MAC3:    w_ch = 2'd3;
      default: w_ch = 2'd0;
    endcase
  end

  assign w_mul_s   = r_smp[w_ch];
  assign w_mul_v   = r_vol[w_ch];
  assign w_mul_a   = {{8{w_mul_s[7]}}, w_mul_s};
  assign w_mul_b   = {9'd0, w_mul_v};
  assign w_prod16  = w_mul_a * w_mul_b;
  assign w_prod    = {w_prod16[15], w_prod16};
  assign w_to_left = STEREO ? ((w_ch == 2'd0) || (w_ch == 2'd3)) : 1'b1;

  // The mixed value always fits in 16 bits, so the sign is taken from the top accumulator bit.
  assign w_res_l = STEREO ? {r_acc_l[15], r_acc_l[13:0], 1'b0} : {r_acc_l[16], r_acc_l[14:0]};
  assign w_res_r = STEREO ? {r_acc_r[15], r_acc_r[13:0], 1'b0} : {r_acc_l[16], r_acc_l[14:0]};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 4; i++) begin
        r_smp[i] <= 8'd0;
        r_vol[i] <= 7'd0;
      end
      r_acc_l     <= 17'sd0;
      r_acc_r     <= 17'sd0;
      r_left_out  <= 16'h8000;
      r_right_out <= 16'h8000;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.sample_strobe) begin
            for (int i = 0; i < 4; i++) begin
              r_smp[i] <= w_in_smp[i];
              r_vol[i] <= w_vol_clamp[i];
            end
            r_acc_l <= 17'sd0;
            r_acc_r <= 17'sd0;
          end
        end
        MAC0, MAC1, MAC2, MAC3: begin
          if (w_to_left) r_acc_l <= r_acc_l + w_prod;
          else           r_acc_r <= r_acc_r + w_prod;
        end
        OUT: begin
          r_left_out  <= w_res_l ^ 16'h8000;
          r_right_out <= w_res_r ^ 16'h8000;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.left_out  = r_left_out;
  assign bus.right_out = r_right_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_paula_audio_mixer.sv
// Directed bench for paula_audio_mixer: a stereo and a mono instance share the
// same stimulus; each scenario task checks hand-computed results inline.
module tb_paula_audio_mixer;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic       strobe = 1'b0;
  logic [7:0] smp [4];
  logic [6:0] vol [4];

  int n_checks = 0;
  int n_fail   = 0;

  paula_audio_mixer_if s_if ();
  paula_audio_mixer_if m_if ();

  paula_audio_mixer #(.STEREO(1'b1)) u_stereo (.clk(clk), .n_reset(n_reset), .bus(s_if.slave));
  paula_audio_mixer #(.STEREO(1'b0)) u_mono   (.clk(clk), .n_reset(n_reset), .bus(m_if.slave));

  assign s_if.sample_strobe = strobe;
  assign s_if.ch0_sample = smp[0];
  assign s_if.ch1_sample = smp[1];
  assign s_if.ch2_sample = smp[2];
  assign s_if.ch3_sample = smp[3];
  assign s_if.ch0_vol = vol[0];
  assign s_if.ch1_vol = vol[1];
  assign s_if.ch2_vol = vol[2];
  assign s_if.ch3_vol = vol[3];
  assign m_if.sample_strobe = strobe;
  assign m_if.ch0_sample = smp[0];
  assign m_if.ch1_sample = smp[1];
  assign m_if.ch2_sample = smp[2];
  assign m_if.ch3_sample = smp[3];
  assign m_if.ch0_vol = vol[0];
  assign m_if.ch1_vol = vol[1];
  assign m_if.ch2_vol = vol[2];
  assign m_if.ch3_vol = vol[3];

  task automatic set_all(input logic [7:0] s, input logic [6:0] v);
    for (int i = 0; i < 4; i++) begin
      smp[i] = s;
      vol[i] = v;
    end
  endtask

  // One strobe; lat = edges from the accepting edge to the out_valid edge (0 on timeout).
  task automatic mix(output int lat, output logic busy_t);
    @(posedge clk); #1 strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
    busy_t = s_if.busy;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (s_if.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    set_all(8'd0, 7'd0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (s_if.left_out !== 16'h8000) begin n_fail++; $display("FAIL reset_left got=%h exp=8000", s_if.left_out); end
    n_checks++; if (s_if.right_out !== 16'h8000) begin n_fail++; $display("FAIL reset_right got=%h exp=8000", s_if.right_out); end
    n_checks++; if (s_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", s_if.busy); end
    n_checks++; if (s_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", s_if.out_valid); end
    n_checks++; if (m_if.left_out !== 16'h8000) begin n_fail++; $display("FAIL reset_mono_left got=%h exp=8000", m_if.left_out); end
    n_reset = 1'b1;
    $display("reset: left=%h right=%h busy=%b", s_if.left_out, s_if.right_out, s_if.busy);
  endtask

  task automatic test_full_pos;
    int lat; logic bt;
    set_all(8'd127, 7'd64);
    mix(lat, bt);
    $display("full_pos: lat=%0d st L=%h R=%h mono L=%h R=%h", lat, s_if.left_out, s_if.right_out, m_if.left_out, m_if.right_out);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL full_pos_latency got=%0d exp=5", lat); end
    n_checks++; if (bt !== 1'b1) begin n_fail++; $display("FAIL full_pos_busy got=%b exp=1", bt); end
    n_checks++; if (s_if.left_out !== 16'hFF00) begin n_fail++; $display("FAIL full_pos_left got=%h exp=ff00", s_if.left_out); end
    n_checks++; if (s_if.right_out !== 16'hFF00) begin n_fail++; $display("FAIL full_pos_right got=%h exp=ff00", s_if.right_out); end
    n_checks++; if (m_if.left_out !== 16'hFF00) begin n_fail++; $display("FAIL mono_full_left got=%h exp=ff00", m_if.left_out); end
    n_checks++; if (m_if.right_out !== 16'hFF00) begin n_fail++; $display("FAIL mono_full_right got=%h exp=ff00", m_if.right_out); end
    @(posedge clk); #1;
    n_checks++; if (s_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pos_pulse_width got=%b exp=0", s_if.out_valid); end
  endtask

  task automatic test_reset_mid_mix;
    int lat; logic bt; int seen;
    set_all(8'd127, 7'd64);
    @(posedge clk); #1 strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 n_reset = 1'b0;
    #1;
    n_checks++; if (s_if.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", s_if.busy); end
    n_checks++; if (s_if.left_out !== 16'h8000) begin n_fail++; $display("FAIL midreset_left got=%h exp=8000", s_if.left_out); end
    n_checks++; if (s_if.right_out !== 16'h8000) begin n_fail++; $display("FAIL midreset_right got=%h exp=8000", s_if.right_out); end
    @(posedge clk); #1 n_reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (s_if.out_valid || m_if.out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_valid got=%0d exp=0", seen); end
    smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30; smp[3] = 8'd40;
    vol[0] = 7'd64; vol[1] = 7'd32; vol[2] = 7'd16; vol[3] = 7'd8;
    mix(lat, bt);
    $display("after_reset: lat=%0d st L=%h R=%h mono L=%h", lat, s_if.left_out, s_if.right_out, m_if.left_out);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL after_reset_latency got=%0d exp=5", lat); end
    n_checks++; if (s_if.left_out !== 16'h8780) begin n_fail++; $display("FAIL after_reset_left got=%h exp=8780", s_if.left_out); end
    n_checks++; if (s_if.right_out !== 16'h88C0) begin n_fail++; $display("FAIL after_reset_right got=%h exp=88c0", s_if.right_out); end
    n_checks++; if (m_if.left_out !== 16'h8820) begin n_fail++; $display("FAIL after_reset_mono got=%h exp=8820", m_if.left_out); end
  endtask

  task automatic test_neg_sep;
    int lat; logic bt;
    set_all(8'd0, 7'd64);
    smp[0] = 8'h80; smp[3] = 8'h80;
    mix(lat, bt);
    $display("neg_sep: lat=%0d st L=%h R=%h mono L=%h", lat, s_if.left_out, s_if.right_out, m_if.left_out);
    n_checks++; if (s_if.left_out !== 16'h0000) begin n_fail++; $display("FAIL neg_left got=%h exp=0000", s_if.left_out); end
    n_checks++; if (s_if.right_out !== 16'h8000) begin n_fail++; $display("FAIL neg_right got=%h exp=8000", s_if.right_out); end
    n_checks++; if (m_if.right_out !== 16'h4000) begin n_fail++; $display("FAIL neg_mono got=%h exp=4000", m_if.right_out); end
  endtask

  task automatic test_clamp_snapshot;
    int lat;
    set_all(8'd0, 7'd0);
    smp[1] = 8'd64; vol[1] = 7'd100;
    @(posedge clk); #1 strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
    @(posedge clk); #1 smp[1] = 8'hC0; vol[1] = 7'd0;
    lat = 0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      if (s_if.out_valid) begin
        lat = k;
        break;
      end
    end
    $display("clamp_snapshot: lat=%0d st L=%h R=%h mono L=%h", lat, s_if.left_out, s_if.right_out, m_if.left_out);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL clamp_latency got=%0d exp=5", lat); end
    n_checks++; if (s_if.right_out !== 16'hA000) begin n_fail++; $display("FAIL clamp_right got=%h exp=a000", s_if.right_out); end
    n_checks++; if (s_if.left_out !== 16'h8000) begin n_fail++; $display("FAIL clamp_left got=%h exp=8000", s_if.left_out); end
    n_checks++; if (m_if.left_out !== 16'h9000) begin n_fail++; $display("FAIL clamp_mono got=%h exp=9000", m_if.left_out); end
  endtask

  task automatic test_mono_small;
    int lat; logic bt;
    set_all(8'd0, 7'd0);
    smp[2] = 8'hFF; vol[2] = 7'd1;
    mix(lat, bt);
    $display("mono_small: lat=%0d mono L=%h R=%h st L=%h R=%h", lat, m_if.left_out, m_if.right_out, s_if.left_out, s_if.right_out);
    n_checks++; if (m_if.left_out !== 16'h7FFF) begin n_fail++; $display("FAIL mono_small_left got=%h exp=7fff", m_if.left_out); end
    n_checks++; if (m_if.right_out !== 16'h7FFF) begin n_fail++; $display("FAIL mono_small_right got=%h exp=7fff", m_if.right_out); end
    n_checks++; if (s_if.right_out !== 16'h7FFE) begin n_fail++; $display("FAIL st_small_right got=%h exp=7ffe", s_if.right_out); end
    n_checks++; if (s_if.left_out !== 16'h8000) begin n_fail++; $display("FAIL st_small_left got=%h exp=8000", s_if.left_out); end
  endtask

  task automatic test_back_to_back;
    int pulses[$];
    int idle_cnt;
    int bad_out;
    set_all(8'd127, 7'd64);
    idle_cnt = 0;
    bad_out = 0;
    @(posedge clk); #1 strobe = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (s_if.out_valid) begin
        pulses.push_back(c);
        if (s_if.left_out !== 16'hFF00 || s_if.right_out !== 16'hFF00) bad_out++;
      end
      if (!s_if.busy) idle_cnt++;
    end
    strobe = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("back_to_back: pulses=%0d idle_samples=%0d", pulses.size(), idle_cnt);
    n_checks++; if (pulses.size() !== 6) begin n_fail++; $display("FAIL b2b_pulse_count got=%0d exp=6", pulses.size()); end
    if (pulses.size() > 0) begin
      n_checks++; if (pulses[0] !== 6) begin n_fail++; $display("FAIL b2b_first_pulse got=%0d exp=6", pulses[0]); end
    end
    for (int i = 1; i < pulses.size(); i++) begin
      n_checks++;
      if (pulses[i] - pulses[i-1] !== 6) begin
        n_fail++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=6", i, pulses[i] - pulses[i-1]);
      end
    end
    n_checks++; if (idle_cnt !== 6) begin n_fail++; $display("FAIL b2b_idle_samples got=%0d exp=6", idle_cnt); end
    n_checks++; if (bad_out !== 0) begin n_fail++; $display("FAIL b2b_outputs got=%0d bad exp=0", bad_out); end
  endtask

  initial begin
    test_reset();
    test_full_pos();
    test_reset_mid_mix();
    test_neg_sep();
    test_clamp_snapshot();
    test_mono_small();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
